// File: rtl/hwag_crank_emulator.sv
// Missing-tooth crank-wheel generator (default 60-2) used as on-chip stimulus for HWAG capture.
// One slot lasts period_q ena ticks; the last TOOTH_MISSING slots of each revolution stay low.
module hwag_crank_emulator #(
  parameter int PCNT_WIDTH    = 24,
  parameter int TOOTH_TOTAL   = 60,
  parameter int TOOTH_MISSING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  run,
  input  logic [PCNT_WIDTH-1:0] period,
  output logic                  crank_out,
  output logic [7:0]            slot_num,
  output logic                  gap,
  output logic                  rev_pulse,
  output logic [15:0]           rev_count,
  output logic                  busy
);

  localparam int SLOT_W  = (TOOTH_TOTAL > 1) ? $clog2(TOOTH_TOTAL) : 1;
  localparam int N_TEETH = TOOTH_TOTAL - TOOTH_MISSING;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [PCNT_WIDTH-1:0] r_pcnt;
  logic [PCNT_WIDTH-1:0] r_period_q;
  logic [SLOT_W-1:0]     r_slot;
  logic                  r_crank;
  logic                  r_gap;
  logic                  r_rev_pulse;
  logic [15:0]           r_rev_count;
  logic                  r_busy;

  logic [PCNT_WIDTH-1:0] w_period_eff;
  logic                  w_slot_end;
  logic                  w_wrap;
  logic [SLOT_W-1:0]     w_slot_inc;

  // Periods of 0 and 1 would leave no room for both a high and a low phase.
  assign w_period_eff = (period < PCNT_WIDTH'(2)) ? PCNT_WIDTH'(2) : period;
  assign w_slot_end   = (r_pcnt == r_period_q - PCNT_WIDTH'(1));
  assign w_wrap       = (r_slot == SLOT_W'(TOOTH_TOTAL - 1));
  assign w_slot_inc   = w_wrap ? '0 : r_slot + SLOT_W'(1);

  function automatic logic tooth_hi(input logic [SLOT_W-1:0]     s,
                                    input logic [PCNT_WIDTH-1:0] p,
                                    input logic [PCNT_WIDTH-1:0] q);
    return (s < SLOT_W'(N_TEETH)) && (p < (q >> 1));
  endfunction

  function automatic logic in_gap(input logic [SLOT_W-1:0] s);
    return (s >= SLOT_W'(N_TEETH));
  endfunction

  // NOTE: all state and outputs update with non-blocking assignments so every
  // right-hand side sees the pre-edge values; outputs are derived from the
  // next-state values to stay aligned with pcnt/slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pcnt      <= '0;
      r_period_q  <= '0;
      r_slot      <= '0;
      r_crank     <= 1'b0;
      r_gap       <= 1'b0;
      r_rev_pulse <= 1'b0;
      r_rev_count <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_rev_pulse <= 1'b0;
      if (ena) begin
        unique case (r_state)
          ST_IDLE: begin
            if (run) begin
              r_state    <= ST_RUN;
              r_pcnt     <= '0;
              r_slot     <= '0;
              r_period_q <= w_period_eff;
              r_crank    <= tooth_hi('0, '0, w_period_eff);
              r_gap      <= in_gap('0);
              r_busy     <= 1'b1;
            end
          end
          ST_RUN, ST_DRAIN: begin
            if (!w_slot_end) begin
              r_state <= run ? ST_RUN : ST_DRAIN;
              r_pcnt  <= r_pcnt + PCNT_WIDTH'(1);
              r_crank <= tooth_hi(r_slot, r_pcnt + PCNT_WIDTH'(1), r_period_q);
            end else if (run) begin
              r_state    <= ST_RUN;
              r_pcnt     <= '0;
              r_slot     <= w_slot_inc;
              r_period_q <= w_period_eff;
              r_crank    <= tooth_hi(w_slot_inc, '0, w_period_eff);
              r_gap      <= in_gap(w_slot_inc);
              if (w_wrap) begin
                r_rev_pulse <= 1'b1;
                r_rev_count <= r_rev_count + 16'd1;
              end
            end else begin
              // Stopping at a slot boundary: never step into the next slot.
              r_state <= ST_IDLE;
              r_pcnt  <= '0;
              r_slot  <= '0;
              r_crank <= 1'b0;
              r_gap   <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_crank <= 1'b0;
            r_gap   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign crank_out = r_crank;
  assign slot_num  = 8'(r_slot);
  assign gap       = r_gap;
  assign rev_pulse = r_rev_pulse;
  assign rev_count = r_rev_count;
  assign busy      = r_busy;

endmodule
